// File: rtl/mat_operand_loader_if.sv
// Operand-loader bus: serial word stream in, 24 parallel signed operands out.
// The slave modport is the loader; the master modport is the surrounding datapath.
interface mat_operand_loader_if;
  logic signed [15:0] in_data;
  logic               in_valid;
  logic               in_first;
  logic               in_ready;
  logic signed [15:0] a [16];
  logic signed [15:0] b [8];
  logic               out_valid;
  logic               out_ready;
  logic               frame_err;
  logic [4:0]         word_cnt;

  modport slave (
    input  in_data, in_valid, in_first, out_ready,
    output in_ready, a, b, out_valid, frame_err, word_cnt
  );

  modport master (
    output in_data, in_valid, in_first, out_ready,
    input  in_ready, a, b, out_valid, frame_err, word_cnt
  );
endinterface

// File: rtl/mat_operand_loader.sv
// Serial-to-parallel loader for the 4x4 x 4x2 matrix multiplier operands.
// Collects A (16 words) then B (8 words) and holds them until downstream releases.
module mat_operand_loader (
  input  logic                  clk,
  input  logic                  rst,
  mat_operand_loader_if.slave   bus
);
  localparam int DATA_W = 16;

  typedef enum logic {LOAD, FULL} state_e;

  state_e                    state_q, state_d;
  logic [4:0]                cnt_q, cnt_d;
  logic                      ferr_q, ferr_d;
  logic                      wr_en;
  logic [4:0]                wr_slot;
  logic signed [DATA_W-1:0]  a_q [16];
  logic signed [DATA_W-1:0]  b_q [8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= 5'd0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ferr_d  = 1'b0;
    wr_en   = 1'b0;
    wr_slot = cnt_q;
    case (state_q)
      LOAD: begin
        if (bus.in_valid) begin
          wr_en = 1'b1;
          // A resync marker always restarts the frame at A0, even from slot 23.
          if (bus.in_first) begin
            wr_slot = 5'd0;
            cnt_d   = 5'd1;
            ferr_d  = (cnt_q != 5'd0);
          end else begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd23) state_d = FULL;
          end
        end
      end
      FULL: begin
        if (bus.out_ready) begin
          state_d = LOAD;
          cnt_d   = 5'd0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) a_q[i] <= '0;
      for (int i = 0; i < 8; i++)  b_q[i] <= '0;
    end else if (wr_en) begin
      if (wr_slot < 5'd16) a_q[wr_slot[3:0]] <= bus.in_data;
      else                 b_q[wr_slot[2:0]] <= bus.in_data;
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == FULL);
  assign bus.frame_err = ferr_q;
  assign bus.word_cnt  = cnt_q;
  assign bus.a         = a_q;
  assign bus.b         = b_q;
endmodule

// File: tb/tb_mat_operand_loader.sv
// Randomized bench for mat_operand_loader against a frame-level reference model.
module tb_mat_operand_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mat_operand_loader_if bus ();
  mat_operand_loader dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the words of the current frame, and the last value landed in each slot.
  logic signed [15:0] m_mem [24];
  int                 m_cnt;
  bit                 m_full;
  bit                 m_ferr;

  function automatic logic [383:0] pack_dut();
    logic [383:0] r;
    for (int i = 0; i < 24; i++)
      r[i*16 +: 16] = (i < 16) ? bus.a[i] : bus.b[i-16];
    return r;
  endfunction

  function automatic logic [383:0] pack_model();
    logic [383:0] r;
    for (int i = 0; i < 24; i++) r[i*16 +: 16] = m_mem[i];
    return r;
  endfunction

  task automatic tick();
    if (rst) begin
      m_full = 0; m_cnt = 0; m_ferr = 0;
      for (int i = 0; i < 24; i++) m_mem[i] = '0;
    end else if (m_full) begin
      m_ferr = 0;
      if (bus.out_ready) begin m_full = 0; m_cnt = 0; end
    end else begin
      m_ferr = 0;
      if (bus.in_valid) begin
        if (bus.in_first) begin m_ferr = (m_cnt != 0); m_cnt = 0; end
        m_mem[m_cnt] = bus.in_data;
        m_cnt++;
        if (m_cnt == 24) m_full = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.in_first = 0; bus.out_ready = 0;
  endtask

  task automatic send(input logic signed [15:0] d, input bit first);
    bus.in_data = d; bus.in_valid = 1; bus.in_first = first; bus.out_ready = 0;
    tick();
    idle();
  endtask

  task automatic release_full();
    bus.out_ready = 1; tick(); bus.out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); bus.in_data = '0;
    tick(); tick();
    rst = 0;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got=%b exp=0", bus.frame_err); end
    n_checks++; if (bus.word_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_word_cnt got=%0d exp=0", bus.word_cnt); end
    n_checks++; if (pack_dut() !== 384'd0) begin n_fail++; $display("FAIL reset_operands got=%h exp=0", pack_dut()); end
  endtask

  task automatic test_stream();
    for (int w = 1; w <= 24; w++) begin
      send(16'(w), 0);
      n_checks++; if (bus.word_cnt !== 5'(w)) begin n_fail++; $display("FAIL stream_word_cnt got=%0d exp=%0d", bus.word_cnt, w); end
      n_checks++; if (bus.out_valid !== (w == 24)) begin n_fail++; $display("FAIL stream_out_valid w=%0d got=%b exp=%b", w, bus.out_valid, w == 24); end
    end
    n_checks++; if (bus.a[0] !== 16'sd1 || bus.a[15] !== 16'sd16) begin n_fail++; $display("FAIL stream_A got=%0d,%0d exp=1,16", bus.a[0], bus.a[15]); end
    n_checks++; if (bus.b[0] !== 16'sd17 || bus.b[7] !== 16'sd24) begin n_fail++; $display("FAIL stream_B got=%0d,%0d exp=17,24", bus.b[0], bus.b[7]); end
    n_checks++; if (pack_dut() !== pack_model()) begin n_fail++; $display("FAIL stream_operands got=%h exp=%h", pack_dut(), pack_model()); end
    // Hold in FULL with in_valid and in_first pushed at it: nothing may move.
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1; bus.in_first = 1'($urandom_range(0, 1)); bus.in_data = 16'($urandom);
      tick();
      n_checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_handshake got=%b%b exp=01", bus.in_ready, bus.out_valid); end
      n_checks++; if (bus.frame_err !== 1'b0 || bus.word_cnt !== 5'd24) begin n_fail++; $display("FAIL hold_ctrl got=%b/%0d exp=0/24", bus.frame_err, bus.word_cnt); end
      n_checks++; if (pack_dut() !== pack_model()) begin n_fail++; $display("FAIL hold_operands got=%h exp=%h", pack_dut(), pack_model()); end
    end
    idle();
  endtask

  task automatic test_negative();
    release_full();
    n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_handshake got=%b%b exp=01", bus.out_valid, bus.in_ready); end
    n_checks++; if (bus.word_cnt !== 5'd0) begin n_fail++; $display("FAIL release_word_cnt got=%0d exp=0", bus.word_cnt); end
    send(-16'sd32768, 1); send(16'sd32767, 0); send(-16'sd1, 0);
    for (int w = 3; w < 24; w++) send(16'($urandom), 0);
    n_checks++; if (bus.a[0] !== 16'h8000 || bus.a[1] !== 16'h7FFF || bus.a[2] !== 16'hFFFF) begin n_fail++; $display("FAIL neg_bits got=%h %h %h exp=8000 7fff ffff", bus.a[0], bus.a[1], bus.a[2]); end
    n_checks++; if (pack_dut() !== pack_model()) begin n_fail++; $display("FAIL neg_operands got=%h exp=%h", pack_dut(), pack_model()); end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL neg_out_valid got=%b exp=1", bus.out_valid); end
  endtask

  task automatic test_resync();
    release_full();
    for (int w = 0; w < 7; w++) send(16'($urandom), 0);
    send(16'sd100, 1);
    n_checks++; if (bus.frame_err !== 1'b1) begin n_fail++; $display("FAIL resync_err_pulse got=%b exp=1", bus.frame_err); end
    n_checks++; if (bus.word_cnt !== 5'd1) begin n_fail++; $display("FAIL resync_word_cnt got=%0d exp=1", bus.word_cnt); end
    n_checks++; if (bus.a[0] !== 16'sd100) begin n_fail++; $display("FAIL resync_A0 got=%0d exp=100", bus.a[0]); end
    tick();
    n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL resync_err_width got=%b exp=0", bus.frame_err); end
    for (int w = 0; w < 23; w++) send(16'($urandom), 0);
    n_checks++; if (bus.out_valid !== 1'b1 || bus.word_cnt !== 5'd24) begin n_fail++; $display("FAIL resync_complete got=%b/%0d exp=1/24", bus.out_valid, bus.word_cnt); end
    n_checks++; if (pack_dut() !== pack_model()) begin n_fail++; $display("FAIL resync_operands got=%h exp=%h", pack_dut(), pack_model()); end
  endtask

  task automatic test_bubbles();
    release_full();
    for (int c = 1; c <= 48; c++) begin
      bus.in_valid = (c % 2 == 0); bus.in_data = 16'($urandom);
      bus.in_first = bus.in_valid ? 1'b0 : 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      n_checks++; if (bus.out_valid !== (c == 48)) begin n_fail++; $display("FAIL bubble_out_valid c=%0d got=%b exp=%b", c, bus.out_valid, c == 48); end
      n_checks++; if (bus.word_cnt !== 5'(m_cnt) || bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL bubble_ctrl c=%0d got=%0d/%b exp=%0d/0", c, bus.word_cnt, bus.frame_err, m_cnt); end
    end
    idle();
    n_checks++; if (pack_dut() !== pack_model()) begin n_fail++; $display("FAIL bubble_operands got=%h exp=%h", pack_dut(), pack_model()); end
  endtask

  task automatic test_reset_mid();
    release_full();
    for (int w = 0; w < 12; w++) send(16'($urandom), 0);
    n_checks++; if (bus.word_cnt !== 5'd12) begin n_fail++; $display("FAIL mid_pre_cnt got=%0d exp=12", bus.word_cnt); end
    rst = 1; bus.in_valid = 1; bus.in_data = 16'sd77; tick(); rst = 0; idle();
    n_checks++; if (bus.word_cnt !== 5'd0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ctrl got=%0d/%b exp=0/0", bus.word_cnt, bus.out_valid); end
    n_checks++; if (pack_dut() !== 384'd0) begin n_fail++; $display("FAIL mid_rst_operands got=%h exp=0", pack_dut()); end
    for (int w = 0; w < 24; w++) send(16'($urandom), 0);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL full_pre got=%b exp=1", bus.out_valid); end
    rst = 1; tick(); rst = 0;
    n_checks++; if (bus.word_cnt !== 5'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL full_rst_ctrl got=%0d/%b/%b exp=0/0/1", bus.word_cnt, bus.out_valid, bus.in_ready); end
    n_checks++; if (pack_dut() !== 384'd0) begin n_fail++; $display("FAIL full_rst_operands got=%h exp=0", pack_dut()); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_first  = ($urandom_range(0, 15) == 0);
      bus.in_data   = 16'($urandom);
      bus.out_ready = ($urandom_range(0, 3) == 0);
      tick();
      n_checks++; if (bus.in_ready !== !m_full || bus.out_valid !== m_full) begin n_fail++; $display("FAIL rand_handshake c=%0d got=%b%b exp=%b%b", c, bus.in_ready, bus.out_valid, !m_full, m_full); end
      n_checks++; if (bus.word_cnt !== 5'(m_cnt) || bus.frame_err !== m_ferr) begin n_fail++; $display("FAIL rand_ctrl c=%0d got=%0d/%b exp=%0d/%b", c, bus.word_cnt, bus.frame_err, m_cnt, m_ferr); end
      n_checks++; if (pack_dut() !== pack_model()) begin n_fail++; $display("FAIL rand_operands c=%0d got=%h exp=%h", c, pack_dut(), pack_model()); end
    end
    idle();
  endtask

  initial begin
    m_cnt = 0; m_full = 0; m_ferr = 0;
    for (int i = 0; i < 24; i++) m_mem[i] = '0;
    test_reset();
    test_stream();
    test_negative();
    test_resync();
    test_bubbles();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
